// File: rtl/iommu_reg_pkg.sv
// Shared types and constants for the IOMMU register-bus arbiter.
// Regbus request/response structs are the defaults for the arbiter's type parameters.
package iommu_reg_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} reg_arb_state_e;

  localparam int unsigned ARB_DEF_TIMEOUT = 256;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

endpackage

// File: rtl/iommu_reg_arb_rr.sv
// Rotate-priority picker: returns the first valid requester at or after rr_ptr_i,
// wrapping modulo N_REQ.
module iommu_reg_arb_rr #(
  parameter int unsigned N_REQ = 2,
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0] rr_ptr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_valid_o
);

  localparam int unsigned PW = IDX_W + 1;

  logic [IDX_W-1:0] cand [N_REQ];
  logic [N_REQ-1:0] cand_valid;

  // cand[gi] is the requester with priority rank gi; rr_ptr_i < N_REQ so one wrap suffices
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    logic [PW-1:0] sum;
    assign sum            = {1'b0, rr_ptr_i} + PW'(gi);
    assign cand[gi]       = (sum >= PW'(N_REQ)) ? IDX_W'(sum - PW'(N_REQ)) : IDX_W'(sum);
    assign cand_valid[gi] = valid_i[cand[gi]];
  end

  always_comb begin
    idx_o       = '0;
    any_valid_o = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (cand_valid[i]) begin
        idx_o       = cand[i];
        any_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iommu_reg_arb.sv
// Round-robin arbiter serialising N_REQ reg-bus masters onto one register map,
// one access outstanding, with a watchdog that forces an error response.
module iommu_reg_arb
  import iommu_reg_pkg::*;
#(
  parameter int unsigned N_REQ          = 2,
  parameter int unsigned TIMEOUT_CYCLES = ARB_DEF_TIMEOUT,
  parameter type         reg_req_t      = iommu_reg_pkg::reg_req_t,
  parameter type         reg_rsp_t      = iommu_reg_pkg::reg_rsp_t,
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  reg_req_t         req_i [N_REQ],
  output reg_rsp_t         rsp_o [N_REQ],
  output reg_req_t         req_o,
  input  reg_rsp_t         rsp_i,
  output logic             busy_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             timeout_o
);

  localparam int unsigned WD_W = ($clog2(TIMEOUT_CYCLES + 1) > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  reg_arb_state_e   state_q, state_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] gnt_q, gnt_d;
  logic [WD_W-1:0]  wd_q, wd_d;

  logic [N_REQ-1:0] req_valid;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [IDX_W-1:0] rr_nxt;
  logic             wd_expire;
  reg_rsp_t         rsp_sel;
  logic             rsp_route;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_io
    assign req_valid[gi] = req_i[gi].valid;
    assign rsp_o[gi]     = (rsp_route && (gnt_q == IDX_W'(gi))) ? rsp_sel : reg_rsp_t'('0);
  end

  iommu_reg_arb_rr #(.N_REQ(N_REQ)) u_rr (
    .valid_i     (req_valid),
    .rr_ptr_i    (rr_q),
    .idx_o       (pick_idx),
    .any_valid_o (pick_any)
  );

  assign rr_nxt    = (gnt_q == IDX_W'(N_REQ - 1)) ? '0 : gnt_q + IDX_W'(1);
  assign wd_expire = (TIMEOUT_CYCLES != 0) && (wd_q == WD_LAST);
  assign busy_o    = (state_q == ARB_BUSY);
  assign gnt_idx_o = gnt_q;

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gnt_d     = gnt_q;
    wd_d      = wd_q;
    req_o     = '0;
    rsp_sel   = '0;
    rsp_route = 1'b0;
    timeout_o = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_idx;
          wd_d    = '0;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (!req_i[gnt_q].valid) begin
          // master withdrew mid-access: drop it silently, but it still loses its turn
          rr_d    = rr_nxt;
          wd_d    = '0;
          state_d = ARB_IDLE;
        end else begin
          req_o       = req_i[gnt_q];
          req_o.valid = 1'b1;
          rsp_route   = 1'b1;
          rsp_sel     = rsp_i;
          if (rsp_i.ready) begin
            rr_d    = rr_nxt;
            wd_d    = '0;
            state_d = ARB_IDLE;
          end else if (wd_expire) begin
            req_o.valid   = 1'b0;
            rsp_sel.rdata = '0;
            rsp_sel.error = 1'b1;
            rsp_sel.ready = 1'b1;
            timeout_o     = 1'b1;
            rr_d          = rr_nxt;
            wd_d          = '0;
            state_d       = ARB_IDLE;
          end else if (wd_q != '1) begin
            wd_d = wd_q + WD_W'(1);
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      wd_q    <= wd_d;
    end
  end

endmodule

// File: tb/tb_iommu_reg_arb.sv
// Scoreboard bench for iommu_reg_arb: two masters, TIMEOUT_CYCLES=8, a latency-programmable
// register map model; addr[11:8] selects response latency, addr[6] the master's private region.
module tb_iommu_reg_arb;
  import iommu_reg_pkg::*;

  localparam int N  = 2;
  localparam int TO = 8;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  reg_req_t    req [N];
  reg_rsp_t    rsp [N];
  reg_req_t    req_o;
  reg_rsp_t    rsp_i;
  logic        busy;
  logic        timeout;
  logic [0:0]  gnt_idx;

  always #5 clk = ~clk;

  iommu_reg_arb #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .req_i     (req),
    .rsp_o     (rsp),
    .req_o     (req_o),
    .rsp_i     (rsp_i),
    .busy_o    (busy),
    .gnt_idx_o (gnt_idx),
    .timeout_o (timeout)
  );

  int   n_chk = 0;
  int   n_pass = 0;
  int   n_to = 0;
  int   n_exp_to = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   grants[$];
  logic [31:0] mem    [32];
  logic [31:0] refmem [32];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
  endtask

  task automatic fail(input string nm);
    n_chk++;
    $display("FAIL %s: bounded wait expired", nm);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  // Reference: who should be served, derived only from the round-robin rule
  logic [N-1:0] vvec;
  int m_q, ptr_q;
  always_comb for (int k = 0; k < N; k++) vvec[k] = req[k].valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q   <= 0;
      ptr_q <= 0;
    end else if (!busy && pick(vvec, ptr_q) >= 0) begin
      m_q   <= pick(vvec, ptr_q);
      ptr_q <= (pick(vvec, ptr_q) + 1) % N;
    end
  end

  // Register map model: answers after addr[11:8] BUSY cycles, pokes stray ready while idle
  int   busy_cnt;
  logic spur_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt <= 0;
      spur_q   <= 1'b0;
    end else begin
      busy_cnt <= busy ? busy_cnt + 1 : 0;
      spur_q   <= ($urandom_range(0, 3) == 0);
    end
  end

  always_comb begin
    rsp_i = '0;
    if (busy) begin
      rsp_i.ready = (busy_cnt == int'(req[m_q].addr[11:8]));
      rsp_i.rdata = req[m_q].write ? 32'h0 : mem[req[m_q].addr[6:2]];
    end else begin
      rsp_i.ready = spur_q;
      rsp_i.rdata = 32'hBAD0_BAD0;
    end
  end

  always @(posedge clk) begin
    if (rst_n && req_o.valid && rsp_i.ready && req_o.write)
      mem[req_o.addr[6:2]] <= merge(mem[req_o.addr[6:2]], req_o.wdata, req_o.wstrb);
  end

  task automatic push_exp(input int k, input logic [31:0] addr, input logic wr,
                          input logic [31:0] wd, input logic [3:0] st);
    exp_t e;
    int key;
    int lat;
    key = int'(addr[6:2]);
    lat = int'(addr[11:8]);
    if (lat >= TO) begin
      e.rdata = 32'h0;
      e.err   = 1'b1;
      n_exp_to++;
    end else if (wr) begin
      refmem[key] = merge(refmem[key], wd, st);
      e.rdata = 32'h0;
      e.err   = 1'b0;
    end else begin
      e.rdata = refmem[key];
      e.err   = 1'b0;
    end
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic issue(input int k, input logic [31:0] addr, input logic wr,
                       input logic [31:0] wd, input logic [3:0] st, output int nbusy);
    int t;
    nbusy = 0;
    t     = 0;
    push_exp(k, addr, wr, wd, st);
    req[k] = '{addr: addr, write: wr, wdata: wd, wstrb: st, valid: 1'b1};
    forever begin
      @(negedge clk);
      if (busy && int'(gnt_idx) == k) nbusy++;
      if (rsp[k].ready) break;
      t++;
      if (t > 200) begin
        fail($sformatf("issue_wait_m%0d", k));
        break;
      end
    end
    @(posedge clk);
    #1 req[k].valid = 1'b0;
  endtask

  task automatic rand_master(input int k, input int count);
    int lat_tab [10] = '{0, 0, 1, 2, 3, 5, 7, 8, 12, 15};
    int nb;
    logic [31:0] addr;
    for (int i = 0; i < count; i++) begin
      addr = (32'(lat_tab[$urandom_range(0, 9)]) << 8) | (32'(k) << 6) | (32'($urandom_range(0, 15)) << 2);
      issue(k, addr, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(1, 15)), nb);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  // Response monitor: pops the scoreboard whenever a master sees ready
  always @(negedge clk) begin
    if (rst_n) begin
      int nr;
      exp_t e;
      nr = 0;
      for (int k = 0; k < N; k++) if (rsp[k].ready) nr++;
      if (timeout) begin
        n_to++;
        check("timeout_req_valid", 32'(req_o.valid), 32'd0);
        if (nr == 0) check("timeout_has_rsp", 32'(nr), 32'd1);
      end
      for (int k = 0; k < N; k++) begin
        if (rsp[k].ready) begin
          $display("rsp m%0d rdata=0x%08h err=%0d timeout=%0d", k, rsp[k].rdata, rsp[k].error, timeout);
          check("rsp_only_in_busy", 32'(busy), 32'd1);
          check("other_rsp_zero", 32'(rsp[1-k] == '0), 32'd1);
          if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            check($sformatf("unexpected_rsp_m%0d", k), 32'(rsp[k].ready), 32'd0);
          end else begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("rdata_m%0d", k), rsp[k].rdata, e.rdata);
            check($sformatf("error_m%0d", k), 32'(rsp[k].error), 32'(e.err));
            check($sformatf("timeout_flag_m%0d", k), 32'(timeout), 32'(e.err));
          end
        end
      end
    end
  end

  // Grant monitor: winner and forwarded request against the round-robin reference
  logic busy_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_prev <= 1'b0;
    end else begin
      busy_prev <= busy;
      if (busy && !busy_prev) begin
        check("grant_idx", 32'(gnt_idx), 32'(m_q));
        grants.push_back(int'(gnt_idx));
      end
      if (busy && req_o.valid) begin
        check("fwd_addr", req_o.addr, req[m_q].addr);
        check("fwd_wdata", req_o.wdata, req[m_q].wdata);
        check("fwd_ctrl", {27'd0, req_o.write, req_o.wstrb}, {27'd0, req[m_q].write, req[m_q].wstrb});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nb;
    int t0;
    int t;
    for (int k = 0; k < N; k++) req[k] = '0;
    for (int i = 0; i < 32; i++) begin
      mem[i]    = 32'h10 + 32'(4 * i);
      refmem[i] = 32'h10 + 32'(4 * i);
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", 32'(req_o.valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_gnt_idx", 32'(gnt_idx), 32'd0);
    check("rst_rsp_ready", {30'd0, rsp[1].ready, rsp[0].ready}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single write, cycle-exact
    push_exp(0, 32'h18, 1'b1, 32'hDEAD, 4'hF);
    req[0] = '{addr: 32'h18, write: 1'b1, wdata: 32'hDEAD, wstrb: 4'hF, valid: 1'b1};
    @(negedge clk);
    check("t1_idle_valid", 32'(req_o.valid), 32'd0);
    @(negedge clk);
    check("t1_req_valid", 32'(req_o.valid), 32'd1);
    check("t1_rsp0_ready", 32'(rsp[0].ready), 32'd1);
    check("t1_rsp1_ready", 32'(rsp[1].ready), 32'd0);
    @(posedge clk);
    #1 req[0].valid = 1'b0;
    @(negedge clk);
    check("t1_valid_one_cycle", 32'(req_o.valid), 32'd0);
    check("t1_mem_written", mem[6], 32'hDEAD);
    @(posedge clk);
    #1;

    // Read data routing to master 1
    issue(1, 32'h0, 1'b0, 32'h0, 4'h0, nb);
    check("t3_busy_cycles", 32'(nb), 32'd1);

    // Contention: both re-request continuously
    grants.delete();
    fork
      for (int i = 0; i < 4; i++) begin
        int nb0;
        issue(0, 32'h100 | (32'(i) << 2), 1'b0, 32'h0, 4'h0, nb0);
      end
      for (int i = 0; i < 4; i++) begin
        int nb1;
        issue(1, 32'h40 | (32'(i) << 2), 1'b1, 32'hC0DE_0000 + 32'(i), 4'hF, nb1);
      end
    join
    if (grants.size() < 8) check("t2_grant_count", 32'(grants.size()), 32'd8);
    else for (int i = 0; i < 8; i++) check($sformatf("t2_order_%0d", i), 32'(grants[i]), 32'(i % 2));

    // Watchdog expiry, then tie at expiry
    t0 = n_to;
    issue(0, 32'hF04, 1'b0, 32'h0, 4'h0, nb);
    check("t4_busy_cycles", 32'(nb), 32'd8);
    check("t4_timeout_pulses", 32'(n_to - t0), 32'd1);
    t0 = n_to;
    issue(1, 32'h744, 1'b1, 32'h1234_5678, 4'hF, nb);
    check("t5_busy_cycles", 32'(nb), 32'd8);
    check("t5_timeout_pulses", 32'(n_to - t0), 32'd0);
    issue(1, 32'h044, 1'b0, 32'h0, 4'h0, nb);

    // Master withdraws mid-access: no response, turn passes to master 1
    req[0] = '{addr: 32'hF08, write: 1'b0, wdata: 32'h0, wstrb: 4'h0, valid: 1'b1};
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!busy && t < 50);
    if (!busy) fail("abort_wait_busy");
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 req[0].valid = 1'b0;
    @(negedge clk);
    check("abort_req_valid", 32'(req_o.valid), 32'd0);
    check("abort_rsp_ready", {30'd0, rsp[1].ready, rsp[0].ready}, 32'd0);
    @(negedge clk);
    check("abort_idle", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    grants.delete();
    fork
      begin
        int nba;
        issue(0, 32'h0C, 1'b0, 32'h0, 4'h0, nba);
      end
      begin
        int nbb;
        issue(1, 32'h4C, 1'b0, 32'h0, 4'h0, nbb);
      end
    join
    if (grants.size() < 1) check("abort_grant_count", 32'(grants.size()), 32'd1);
    else check("abort_next_grant", 32'(grants[0]), 32'd1);

    // Reset during a long access by master 1
    req[1] = '{addr: 32'hF50, write: 1'b1, wdata: 32'hFFFF_FFFF, wstrb: 4'hF, valid: 1'b1};
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!busy && t < 50);
    if (!busy) fail("reset_wait_busy");
    check("pre_reset_gnt", 32'(gnt_idx), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("reset_req_valid", 32'(req_o.valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_gnt_idx", 32'(gnt_idx), 32'd0);
    req[1].valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    grants.delete();
    fork
      begin
        int nbc;
        issue(0, 32'h10, 1'b0, 32'h0, 4'h0, nbc);
      end
      begin
        int nbd;
        issue(1, 32'h50, 1'b0, 32'h0, 4'h0, nbd);
      end
    join
    if (grants.size() < 1) check("post_reset_grant_count", 32'(grants.size()), 32'd1);
    else check("post_reset_first_grant", 32'(grants[0]), 32'd0);

    // Randomised traffic from both masters
    fork
      rand_master(0, 30);
      rand_master(1, 30);
    join
    repeat (5) @(posedge clk);
    check("timeout_total", 32'(n_to), 32'(n_exp_to));
    check("scoreboard_empty", 32'(q0.size() + q1.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
